// File: rtl/bcd8_conv_arbiter.sv
// Two-requester front end for a serial shift-and-add-3 binary-to-BCD engine.
// Converts a 32-bit two's-complement value into eight BCD digits plus sign/overflow.
module bcd8_conv_arbiter (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0,
    input  logic [31:0] numero0,
    input  logic        req1,
    input  logic [31:0] numero1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        busy,
    output logic        done,
    output logic        done_id,
    output logic [3:0]  d1,
    output logic [3:0]  d2,
    output logic [3:0]  d3,
    output logic [3:0]  d4,
    output logic [3:0]  d5,
    output logic [3:0]  d6,
    output logic [3:0]  d7,
    output logic [3:0]  d8,
    output logic        neg,
    output logic        ovf
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t      state_r;
    logic        last_id_r;
    logic        id_r;
    logic        work_neg_r;
    logic        ovf_acc_r;
    logic [31:0] mag_r;
    logic [31:0] work_r;
    logic [31:0] res_r;
    logic [4:0]  cnt_r;

    logic [31:0] adj_s;
    logic [32:0] chain_s;
    logic        grant_s;
    logic        grant_id_s;
    logic [31:0] sel_num_s;

    function automatic logic [3:0] add3(input logic [3:0] digit);
        logic [3:0] result;
        if (digit >= 4'd5) begin
            result = digit + 4'd3;
        end else begin
            result = digit;
        end
        return result;
    endfunction

    // Digit correction followed by the one-bit chain shift; bit 32 is the carry out of w8.
    always_comb begin
        adj_s = 32'd0;
        for (int i = 0; i < 8; i++) begin
            adj_s[4*i +: 4] = add3(work_r[4*i +: 4]);
        end
        chain_s = {adj_s, mag_r[31]};
    end

    // Round-robin choice between the two requesters; ties go to the one not served last.
    always_comb begin
        grant_s    = 1'b0;
        grant_id_s = 1'b0;
        if (req0 && req1) begin
            grant_s    = 1'b1;
            grant_id_s = ~last_id_r;
        end else if (req0) begin
            grant_s    = 1'b1;
            grant_id_s = 1'b0;
        end else if (req1) begin
            grant_s    = 1'b1;
            grant_id_s = 1'b1;
        end else begin
            grant_s    = 1'b0;
            grant_id_s = 1'b0;
        end
        if (grant_id_s) begin
            sel_num_s = numero1;
        end else begin
            sel_num_s = numero0;
        end
    end

    // Control FSM, conversion datapath and held result registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            last_id_r  <= 1'b1;
            id_r       <= 1'b0;
            work_neg_r <= 1'b0;
            ovf_acc_r  <= 1'b0;
            mag_r      <= 32'd0;
            work_r     <= 32'd0;
            res_r      <= 32'd0;
            cnt_r      <= 5'd0;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            done_id    <= 1'b0;
            neg        <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (grant_s) begin
                        work_neg_r <= sel_num_s[31];
                        mag_r      <= sel_num_s[31] ? (~sel_num_s + 32'd1) : sel_num_s;
                        id_r       <= grant_id_s;
                        last_id_r  <= grant_id_s;
                        work_r     <= 32'd0;
                        ovf_acc_r  <= 1'b0;
                        cnt_r      <= 5'd31;
                        gnt0       <= ~grant_id_s;
                        gnt1       <= grant_id_s;
                        busy       <= 1'b1;
                        state_r    <= ST_SHIFT;
                    end else begin
                        busy       <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    work_r    <= chain_s[31:0];
                    ovf_acc_r <= ovf_acc_r | chain_s[32];
                    mag_r     <= {mag_r[30:0], 1'b0};
                    cnt_r     <= cnt_r - 5'd1;
                    // Last bit consumed: publish the post-shift digits on this same edge.
                    if (cnt_r == 5'd0) begin
                        res_r   <= chain_s[31:0];
                        neg     <= work_neg_r;
                        ovf     <= ovf_acc_r | chain_s[32];
                        done_id <= id_r;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        busy    <= 1'b1;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign d1 = res_r[3:0];
    assign d2 = res_r[7:4];
    assign d3 = res_r[11:8];
    assign d4 = res_r[15:12];
    assign d5 = res_r[19:16];
    assign d6 = res_r[23:20];
    assign d7 = res_r[27:24];
    assign d8 = res_r[31:28];

endmodule

// File: tb/tb_bcd8_conv_arbiter.sv
// Scoreboard bench for bcd8_conv_arbiter: drivers push decimal-arithmetic expectations,
// a monitor pops them on done and also checks that held results stay stable.
module tb_bcd8_conv_arbiter;

    logic        clock;
    logic        reset;
    logic        req0;
    logic [31:0] numero0;
    logic        req1;
    logic [31:0] numero1;
    logic        gnt0, gnt1, busy, done, done_id;
    logic [3:0]  d1, d2, d3, d4, d5, d6, d7, d8;
    logic        neg, ovf;

    typedef struct packed {
        logic [31:0] dig;
        logic        neg;
        logic        ovf;
        logic        id;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   grant_order[$];
    int   n_vec = 0;
    int   n_miss = 0;
    int   gnt1_cnt = 0;
    logic rst_q = 1'b0;

    bcd8_conv_arbiter dut (
        .clock(clock), .reset(reset),
        .req0(req0), .numero0(numero0), .req1(req1), .numero1(numero1),
        .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done), .done_id(done_id),
        .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5), .d6(d6), .d7(d7), .d8(d8),
        .neg(neg), .ovf(ovf)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) rst_q <= reset;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Reference: plain decimal arithmetic on the magnitude.
    function automatic exp_t model(input int id, input logic [31:0] val);
        exp_t e;
        longint mag;
        longint r;
        mag = val[31] ? (64'sh1_0000_0000 - longint'(val)) : longint'(val);
        e.neg = val[31];
        e.ovf = (mag >= 64'sd100000000);
        r = mag % 64'sd100000000;
        e.dig = 32'd0;
        for (int i = 0; i < 8; i++) begin
            e.dig[4*i +: 4] = 4'(r % 64'sd10);
            r = r / 64'sd10;
        end
        e.id = (id != 0);
        return e;
    endfunction

    // Monitor: pops on done, otherwise requires the held result to stay put.
    initial begin
        exp_t held;
        exp_t e;
        logic prev_done;
        held = '0;
        prev_done = 1'b0;
        forever begin
            @(negedge clock);
            if (gnt1) gnt1_cnt++;
            if (rst_q) begin
                held = '0;
                q0.delete();
                q1.delete();
                chk("reset_outputs", {d8, d7, d6, d5, d4, d3, d2, d1, neg, ovf, done_id, done}, 64'd0);
            end else if (done) begin
                if (prev_done) chk("done_width", 64'(prev_done), 64'd0);
                if ((done_id == 1'b0 && q0.size() == 0) || (done_id == 1'b1 && q1.size() == 0)) begin
                    chk("unexpected_done", 64'(done), 64'd0);
                end else begin
                    if (done_id == 1'b0) e = q0.pop_front();
                    else e = q1.pop_front();
                    chk("result", {d8, d7, d6, d5, d4, d3, d2, d1, neg, ovf, done_id},
                        {e.dig, e.neg, e.ovf, e.id});
                    held = e;
                end
            end else begin
                chk("held", {d8, d7, d6, d5, d4, d3, d2, d1, neg, ovf, done_id},
                    {held.dig, held.neg, held.ovf, held.id});
            end
            prev_done = done;
        end
    end

    // Raise a request, wait for its grant, record the expectation, drop the request.
    task automatic issue(input int id, input logic [31:0] val);
        bit got;
        got = 1'b0;
        if (id == 0) begin numero0 = val; req0 = 1'b1; end
        else begin numero1 = val; req1 = 1'b1; end
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clock);
            if ((id == 0 && gnt0) || (id == 1 && gnt1)) got = 1'b1;
        end
        if (!got) begin
            chk("gnt_timeout", 64'(got), 64'd1);
        end else begin
            grant_order.push_back(id);
            if (id == 0) q0.push_back(model(0, val));
            else q1.push_back(model(1, val));
        end
        if (id == 0) req0 = 1'b0;
        else req1 = 1'b0;
    endtask

    // Called on the negedge right after the grant edge E0.
    task automatic busy_window();
        for (int i = 1; i < 32; i++) begin
            @(negedge clock);
            chk("busy_window", {busy, done, gnt0, gnt1}, 4'b1000);
        end
        @(negedge clock);
        chk("done_edge", {busy, done}, 2'b01);
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 100 && (busy || done); c++) @(negedge clock);
        chk("idle_reached", {busy, done}, 2'b00);
    endtask

    task automatic convert(input int id, input logic [31:0] val);
        issue(id, val);
        busy_window();
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] bnd [8];
        int g1_before;
        bnd[0] = 32'd0;          bnd[1] = 32'd99999999;  bnd[2] = 32'd100000000;
        bnd[3] = 32'h7FFFFFFF;   bnd[4] = 32'h80000000;  bnd[5] = 32'hFFFFFFFF;
        bnd[6] = 32'hFA0A1F01;   bnd[7] = 32'd9;

        reset = 1'b1; req0 = 1'b0; req1 = 1'b0; numero0 = 32'd0; numero1 = 32'd0;
        repeat (3) @(negedge clock);
        chk("reset_ctrl", {gnt0, gnt1, busy, done}, 4'b0000);
        reset = 1'b0;
        @(negedge clock);

        // Tie after reset: requester 0 first, requester 1 right after done.
        fork
            issue(0, 32'd5);
            issue(1, 32'd9);
        join
        wait_idle();
        fork
            issue(0, 32'd5);
            issue(1, 32'd9);
        join
        wait_idle();
        chk("arb_order", {32'(grant_order[0]), 32'(grant_order[1])}, {32'd0, 32'd1});
        chk("arb_order2", {32'(grant_order[2]), 32'(grant_order[3])}, {32'd0, 32'd1});
        @(negedge clock);

        convert(0, 32'd12345678);
        convert(1, 32'hFFFFFFFF);
        convert(0, 32'd123456789);
        convert(1, 32'h80000000);
        convert(0, 32'd99999999);

        // Disturb inputs while busy: running result and arbitration must be unaffected.
        issue(0, 32'd777);
        g1_before = gnt1_cnt;
        fork
            busy_window();
            begin
                @(negedge clock);
                numero0 = $urandom;
                req1 = 1'b1; numero1 = 32'd55;
                repeat (3) @(negedge clock);
                req1 = 1'b0;
            end
        join
        repeat (3) @(negedge clock);
        chk("ignored_req1", 64'(gnt1_cnt), 64'(g1_before));

        // Reset in the middle of a conversion.
        issue(0, $urandom);
        repeat (9) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("mid_reset_ctrl", {busy, done, gnt0, gnt1}, 4'b0000);
        reset = 1'b0;
        repeat (40) @(negedge clock);
        convert(0, 32'd42);

        // Reset on the same edge as a request wins.
        reset = 1'b1; req0 = 1'b1; numero0 = 32'd3;
        @(negedge clock);
        chk("reset_vs_req", {gnt0, busy}, 2'b00);
        reset = 1'b0;
        convert(0, 32'd3);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0: v = $urandom;
                1: v = $urandom_range(0, 99999999);
                2: v = -$urandom_range(0, 99999999);
                default: v = bnd[$urandom_range(0, 7)];
            endcase
            convert(int'($urandom_range(0, 1)), v);
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end

        repeat (2) @(negedge clock);
        chk("queues_drained", {32'(q0.size()), 32'(q1.size())}, 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
